// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: game sequencer for the ttt board core.
//   Arbitrates the two player move ports by turn. Rejects out-of-range and occupied moves.
//   Sends legal moves to the core as one-cycle enable strobes. Detects win, draw and
//   (optionally) turn timeout. Keeps per-player saturating scores across games.
// Optional feature: define TTT_TIMEOUT_EN to build the WAIT_MOVE idle-turn timeout (forfeit).
// Ports:
//   clk_i, reset_ni            clock, synchronous active-low reset
//   start_i                    begin/restart a game from IDLE or GAME_OVER
//   pN_valid_i/x_i/y_i/ready_o move handshake for player N (N = 0, 1)
//   core_reset_o/enable_o/x_o/y_o  clear and move strobe to the board core
//   core_board_i/winner_i/player_i board state, win flag and next-player flag from the core
//   game_over_o, result_o, forfeit_o        game outcome
//   move_err_o, err_code_o, move_count_o    move status
//   score_p0_o, score_p1_o, desync_o        cross-game scores, sticky turn-mismatch flag
module ttt_game_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SCORE_W        = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic               p0_valid_i,
    input  logic [2:0]         p0_x_i,
    input  logic [2:0]         p0_y_i,
    output logic               p0_ready_o,
    input  logic               p1_valid_i,
    input  logic [2:0]         p1_x_i,
    input  logic [2:0]         p1_y_i,
    output logic               p1_ready_o,
    output logic               core_reset_o,
    output logic               core_enable_o,
    output logic [2:0]         core_x_o,
    output logic [2:0]         core_y_o,
    input  logic [17:0]        core_board_i,
    input  logic               core_winner_i,
    input  logic               core_player_i,
    output logic               game_over_o,
    output logic [1:0]         result_o,
    output logic               forfeit_o,
    output logic               move_err_o,
    output logic [1:0]         err_code_o,
    output logic [3:0]         move_count_o,
    output logic [SCORE_W-1:0] score_p0_o,
    output logic [SCORE_W-1:0] score_p1_o,
    output logic               desync_o
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StClear    = 3'd1;
    localparam logic [2:0] StWait     = 3'd2;
    localparam logic [2:0] StValidate = 3'd3;
    localparam logic [2:0] StIssue    = 3'd4;
    localparam logic [2:0] StSettle   = 3'd5;
    localparam logic [2:0] StCheck    = 3'd6;
    localparam logic [2:0] StGameOver = 3'd7;

    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    logic [2:0]         state_q, state_d;
    logic               turn_q, turn_d;
    logic [2:0]         mv_x_q, mv_x_d;
    logic [2:0]         mv_y_q, mv_y_d;
    logic [3:0]         move_count_q, move_count_d;
    logic [1:0]         result_q, result_d;
    logic               move_err_q, move_err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [SCORE_W-1:0] score_p0_q, score_p0_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic               desync_q, desync_d;

    logic       acc_p0, acc_p1;
    logic [8:0] occupied;
    logic [3:0] cell_idx;
    logic       range_err;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            occupied[i] = |core_board_i[2*i +: 2];
        end
    end

    // Only meaningful when range_err is low; the low two bits then hold the whole coordinate.
    assign cell_idx  = 4'(mv_y_q[1:0]) * 4'd3 + 4'(mv_x_q[1:0]);
    assign range_err = (mv_x_q > 3'd2) || (mv_y_q > 3'd2);

    assign acc_p0 = (state_q == StWait) && !turn_q && p0_valid_i;
    assign acc_p1 = (state_q == StWait) && turn_q && p1_valid_i;

`ifdef TTT_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            forfeit_q, forfeit_d;
    logic            tmo_hit;

    // The cycle holding count TIMEOUT_CYCLES-1 is the last idle cycle allowed.
    assign tmo_hit   = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign forfeit_o = forfeit_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign forfeit_o      = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        mv_x_d       = mv_x_q;
        mv_y_d       = mv_y_q;
        move_count_d = move_count_q;
        result_d     = result_q;
        move_err_d   = 1'b0;
        err_code_d   = err_code_q;
        score_p0_d   = score_p0_q;
        score_p1_d   = score_p1_q;
        desync_d     = desync_q;
`ifdef TTT_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        forfeit_d    = forfeit_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StClear;
            end
            StClear: begin
                turn_d       = 1'b0;
                move_count_d = 4'd0;
                result_d     = 2'b00;
`ifdef TTT_TIMEOUT_EN
                tmo_cnt_d    = '0;
                forfeit_d    = 1'b0;
`endif
                state_d      = StWait;
            end
            StWait: begin
                if (acc_p0 || acc_p1) begin
                    mv_x_d  = acc_p0 ? p0_x_i : p1_x_i;
                    mv_y_d  = acc_p0 ? p0_y_i : p1_y_i;
                    state_d = StValidate;
                end else begin
`ifdef TTT_TIMEOUT_EN
                    if (tmo_hit) begin
                        // Idle player forfeits; the opponent takes the win.
                        forfeit_d = 1'b1;
                        result_d  = turn_q ? 2'b01 : 2'b10;
                        if (turn_q) begin
                            if (score_p0_q != ScoreMax) score_p0_d = score_p0_q + 1'b1;
                        end else begin
                            if (score_p1_q != ScoreMax) score_p1_d = score_p1_q + 1'b1;
                        end
                        state_d = StGameOver;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
`endif
                end
            end
            StValidate: begin
                if (range_err) begin
                    move_err_d = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = StWait;
                end else if (occupied[cell_idx]) begin
                    move_err_d = 1'b1;
                    err_code_d = 2'b10;
                    state_d    = StWait;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef TTT_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = StSettle;
            end
            StSettle: begin
                state_d = StCheck;
            end
            StCheck: begin
                move_count_d = move_count_q + 4'd1;
                // The core should now name the player we are about to toggle to.
                if (core_player_i == turn_q) desync_d = 1'b1;
                if (core_winner_i) begin
                    result_d = turn_q ? 2'b10 : 2'b01;
                    if (turn_q) begin
                        if (score_p1_q != ScoreMax) score_p1_d = score_p1_q + 1'b1;
                    end else begin
                        if (score_p0_q != ScoreMax) score_p0_d = score_p0_q + 1'b1;
                    end
                    state_d = StGameOver;
                end else if (&occupied) begin
                    result_d = 2'b11;
                    state_d  = StGameOver;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = StWait;
                end
            end
            StGameOver: begin
                if (start_i) state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            turn_q       <= 1'b0;
            mv_x_q       <= 3'd0;
            mv_y_q       <= 3'd0;
            move_count_q <= 4'd0;
            result_q     <= 2'b00;
            move_err_q   <= 1'b0;
            err_code_q   <= 2'b00;
            score_p0_q   <= '0;
            score_p1_q   <= '0;
            desync_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            mv_x_q       <= mv_x_d;
            mv_y_q       <= mv_y_d;
            move_count_q <= move_count_d;
            result_q     <= result_d;
            move_err_q   <= move_err_d;
            err_code_q   <= err_code_d;
            score_p0_q   <= score_p0_d;
            score_p1_q   <= score_p1_d;
            desync_q     <= desync_d;
        end
    end

`ifdef TTT_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            tmo_cnt_q <= '0;
            forfeit_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            forfeit_q <= forfeit_d;
        end
    end
`endif

    assign p0_ready_o    = (state_q == StWait) && !turn_q;
    assign p1_ready_o    = (state_q == StWait) && turn_q;
    assign core_reset_o  = (state_q == StIdle) || (state_q == StClear);
    assign core_enable_o = (state_q == StIssue);
    assign core_x_o      = core_enable_o ? mv_x_q : 3'd0;
    assign core_y_o      = core_enable_o ? mv_y_q : 3'd0;
    assign game_over_o   = (state_q == StGameOver);
    assign result_o      = result_q;
    assign move_err_o    = move_err_q;
    assign err_code_o    = err_code_q;
    assign move_count_o  = move_count_q;
    assign score_p0_o    = score_p0_q;
    assign score_p1_o    = score_p1_q;
    assign desync_o      = desync_q;

endmodule
